thread_scheduler: RTL

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

---
 rtl/mt_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/thread_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mt_pkg.sv
// Shared types and default sizing for the multithreaded issue scheduler.
package mt_pkg;

  // Per-thread scheduling state.
  typedef enum logic [1:0] {
    TH_IDLE  = 2'd0,
    TH_READY = 2'd1,
    TH_WAIT  = 2'd2
  } thread_state_e;

  localparam int DEF_NUM_THREADS = 4;
  localparam int DEF_WAIT_W      = 4;

endpackage : mt_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches the request mask starting at
// the entry after last_idx, wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_idx,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // Scan offsets 1..N from last_idx and take the first requester found.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    gnt_valid = 1'b0;
    gnt_idx   = last_idx;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(last_idx) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!gnt_valid && req[cand_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/thread_scheduler.sv
// Fine-grained multithread issue scheduler: per-thread IDLE/READY/WAIT
// tracking, round-robin issue to fetch, and register-file group switching.
// Optional feature: define SCHED_IDLE_CNT_EN to add the 32-bit idle_cnt
// output counting unstalled cycles with no issue.
module thread_scheduler
  import mt_pkg::*;
#(
  parameter  int NUM_THREADS  = DEF_NUM_THREADS,
  parameter  int WAIT_W       = DEF_WAIT_W,
  localparam int BITS_THREADS = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_THREADS-1:0]  thread_en,
  input  logic                    stall,
  input  logic                    park_valid,
  input  logic [BITS_THREADS-1:0] park_tid,
  input  logic [WAIT_W-1:0]       park_cycles,
  input  logic                    grp_switch_req,
  output logic                    grp_switch_ack,
  output logic [BITS_THREADS-1:0] tid_f,
  output logic                    tid_valid_f,
  output logic                    tgrp,
`ifdef SCHED_IDLE_CNT_EN
  output logic [31:0]             idle_cnt,
`endif
  output logic [NUM_THREADS-1:0]  ready_mask
);

  logic [NUM_THREADS-1:0] wait_mask;
  logic [NUM_THREADS-1:0] kill_mask;
  logic [NUM_THREADS-1:0] issue_req;

  logic [BITS_THREADS-1:0] tid_q, tid_d;
  logic                    vld_q, vld_d;
  logic [BITS_THREADS-1:0] last_q, last_d;
  logic                    tgrp_q, tgrp_d;
  logic                    ack_q, ack_d;
  logic                    pend_q, pend_d;
  logic                    pend_eff;
  logic                    apply_sw;

  logic                    gnt_valid;
  logic [BITS_THREADS-1:0] gnt_idx;

  for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thr
    thread_state_e     st_q, st_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              park_hit;

    assign park_hit = park_valid && (park_tid == BITS_THREADS'(gi)) &&
                      (park_cycles != '0);

    // Thread state machine: disable dominates, park loads or reloads the
    // counter, and the counter runs down even while the pipeline stalls.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (!thread_en[gi]) begin
        st_d  = TH_IDLE;
        cnt_d = '0;
      end else begin
        case (st_q)
          TH_IDLE: st_d = TH_READY;
          TH_READY: begin
            if (park_hit) begin
              st_d  = TH_WAIT;
              cnt_d = park_cycles;
            end
          end
          TH_WAIT: begin
            if (park_hit) begin
              cnt_d = park_cycles;
            end else if (cnt_q <= WAIT_W'(1)) begin
              st_d  = TH_READY;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q - WAIT_W'(1);
            end
          end
          default: begin
            st_d  = TH_IDLE;
            cnt_d = '0;
          end
        endcase
      end
    end

    // Thread state and park counter registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= TH_IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    assign ready_mask[gi] = (st_q == TH_READY);
    assign wait_mask[gi]  = (st_q == TH_WAIT);
    assign kill_mask[gi]  = park_hit;
  end : g_thr

  // A thread being parked or disabled this cycle must not be issued next
  // cycle, even though its registered state still reads READY.
  assign issue_req = ready_mask & thread_en & ~kill_mask;

  rr_arbiter #(
    .N     (NUM_THREADS),
    .IDX_W (BITS_THREADS)
  ) u_rr (
    .req       (issue_req),
    .last_idx  (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Issue and group-switch decisions; the switch cycle issues nothing so
  // the register file sees a clean bubble while tgrp flips.
  always_comb begin
    tid_d    = tid_q;
    vld_d    = vld_q;
    last_d   = last_q;
    tgrp_d   = tgrp_q;
    ack_d    = 1'b0;
    pend_eff = pend_q | (grp_switch_req & ~ack_q);
    apply_sw = pend_eff & ~(|wait_mask) & ~stall;
    pend_d   = pend_eff & ~apply_sw;
    if (apply_sw) begin
      ack_d  = 1'b1;
      tgrp_d = ~tgrp_q;
    end
    if (!stall) begin
      if (apply_sw) begin
        vld_d = 1'b0;
      end else if (gnt_valid) begin
        tid_d  = gnt_idx;
        vld_d  = 1'b1;
        last_d = gnt_idx;
      end else begin
        vld_d = 1'b0;
      end
    end
  end

  // Issue, pointer and group-switch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tid_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= BITS_THREADS'(NUM_THREADS - 1);
      tgrp_q <= 1'b0;
      ack_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      tid_q  <= tid_d;
      vld_q  <= vld_d;
      last_q <= last_d;
      tgrp_q <= tgrp_d;
      ack_q  <= ack_d;
      pend_q <= pend_d;
    end
  end

  assign tid_f          = tid_q;
  assign tid_valid_f    = vld_q;
  assign tgrp           = tgrp_q;
  assign grp_switch_ack = ack_q;

`ifdef SCHED_IDLE_CNT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;

  // Count unstalled cycles without an issue, saturating at all-ones.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (!vld_q && !stall && (idle_cnt_q != '1)) begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign idle_cnt = idle_cnt_q;
`endif

endmodule : thread_scheduler
